// File: rtl/frame_buf_scanout.sv
// frame_buf_scanout
// Reader side of the frame buffer. A start pulse launches one frame of
// sequential reads; returned pixels land in a small prefetch FIFO whose
// occupancy plus outstanding reads never exceeds its depth. The FIFO head is
// streamed to the display encoder on a valid/ready interface with raster
// markers derived from the head pixel's x/y position.
module frame_buf_scanout #(
  parameter int H_PIX      = 320,
  parameter int V_PIX      = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 1,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic              frame_buf_re,
  output logic [16:0]       frame_buf_addr,
  input  logic [DATA_W-1:0] frame_buf_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int ADDR_W = 17;
  localparam int NPIX   = H_PIX * V_PIX;
  localparam int X_W    = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int Y_W    = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_PIX - 1);
  localparam logic [X_W-1:0]    X_ONE     = X_W'(1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_PIX - 1);
  localparam logic [Y_W-1:0]    Y_ONE     = Y_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W:0]      used;
  logic                credit_ok;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [RD_LAT-1:0]   re_dly_p;
  logic                push;
  logic                pop;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic                at_x_last;
  logic                at_y_last;

  // Credit check is deliberately conservative: a pop in the same cycle does
  // not free a slot until the following cycle.
  assign used      = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok = (used < DEPTH_EXT);

  assign frame_buf_re = (state == FETCH) && credit_ok;
  assign push         = re_dly_p[RD_LAT-1];

  assign pix_valid = (fifo_count != '0);
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = fifo_mem[rd_ptr];

  assign at_x_last = (x == X_LAST);
  assign at_y_last = (y == Y_LAST);
  assign pix_sof   = pix_valid && (x == '0) && (y == '0);
  assign pix_eol   = pix_valid && at_x_last;
  assign pix_eof   = pix_valid && at_x_last && at_y_last;

  // Frame sequencer: owns done and the read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      done           <= 1'b1;
      frame_buf_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            done  <= 1'b0;
          end
        end
        FETCH: begin
          if (frame_buf_re) begin
            if (frame_buf_addr == ADDR_LAST) begin
              frame_buf_addr <= '0;
              state          <= DRAIN;
            end else begin
              frame_buf_addr <= frame_buf_addr + ADDR_ONE;
            end
          end
        end
        DRAIN: begin
          if (pop && pix_eof) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b1;
        end
      endcase
    end
  end

  // ---- stage p0..p(RD_LAT-1): read strobe delayed to match frame-buffer latency
  // Tracks which cycles carry returning data and how many reads are outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_dly_p <= '0;
      inflight <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        re_dly_p[i] <= re_dly_p[i-1];
      end
      re_dly_p[0] <= frame_buf_re;
      case ({frame_buf_re, push})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---- FIFO storage: returning pixel data captured on the delayed strobe
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= frame_buf_data;
    end
  end

  // Raster position of the FIFO head, advanced on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (pop) begin
      if (at_x_last) begin
        x <= '0;
        if (at_y_last) begin
          y <= '0;
        end else begin
          y <= y + Y_ONE;
        end
      end else begin
        x <= x + X_ONE;
      end
    end
  end

  // The credit scheme must never let returning data find the FIFO full.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_frame_buf_scanout.sv
// Testbench for frame_buf_scanout: a reduced 32x8 frame with a latency-2
// frame-buffer model. Expected pixels are queued when a start is accepted and
// checked by an independent monitor on every handshake.
`timescale 1ns/1ps
module tb_frame_buf_scanout;

  localparam int H     = 32;
  localparam int V     = 8;
  localparam int NPIX  = H * V;
  localparam int DEPTH = 8;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic        done;
  logic        frame_buf_re;
  logic [16:0] frame_buf_addr;
  logic [23:0] frame_buf_data;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  always #5 clk = ~clk;

  frame_buf_scanout #(
    .H_PIX(H), .V_PIX(V), .FIFO_DEPTH(DEPTH), .RD_LAT(LAT), .DATA_W(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .done(done),
    .frame_buf_re(frame_buf_re),
    .frame_buf_addr(frame_buf_addr),
    .frame_buf_data(frame_buf_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_sof(pix_sof),
    .pix_eol(pix_eol),
    .pix_eof(pix_eof)
  );

  // Frame-buffer model: data appears LAT cycles after the strobe, garbage otherwise.
  logic [23:0] mem [NPIX];
  logic [23:0] rdq [LAT];
  always @(posedge clk) begin
    rdq[0] <= frame_buf_re ? mem[int'(frame_buf_addr) % NPIX] : 24'($urandom);
    for (int i = 1; i < LAT; i++) rdq[i] <= rdq[i-1];
  end
  assign frame_buf_data = rdq[LAT-1];

  int errors = 0;
  int checks = 0;

  logic [26:0] exp_q [$];
  logic        busy = 1'b0;
  logic        was_busy;
  int          left = 0;
  int          issued = 0;
  int          accepted = 0;
  int          exp_addr = 0;
  logic        hold_v = 1'b0;
  logic [26:0] hold_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected stream element: pixel data plus raster markers for index i.
  function automatic logic [26:0] exp_pix(input int i);
    return {mem[i], i == 0, (i % H) == H - 1, i == NPIX - 1};
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_outputs",
            32'({done, frame_buf_re, frame_buf_addr, pix_valid, pix_sof, pix_eol, pix_eof}),
            32'({1'b1, 1'b0, 17'd0, 4'b0000}));
      exp_q.delete();
      busy     = 1'b0;
      left     = 0;
      issued   = 0;
      accepted = 0;
      exp_addr = 0;
      hold_v   = 1'b0;
    end else begin
      was_busy = busy;
      check("done", 32'(done), 32'(!busy));
      if (hold_v)
        check("hold_stable", 32'({pix_valid, pix_data, pix_sof, pix_eol, pix_eof}),
              32'({1'b1, hold_val}));
      hold_v   = pix_valid && !pix_ready;
      hold_val = {pix_data, pix_sof, pix_eol, pix_eof};
      if (frame_buf_re) begin
        check("rd_addr", 32'(frame_buf_addr), 32'(exp_addr));
        check("credit_limit", 32'(issued - accepted < DEPTH), 32'(1));
        exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
        issued++;
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got %0h expected none at %0t", pix_data, $time);
        end else begin
          check("pixel", 32'({pix_data, pix_sof, pix_eol, pix_eof}), 32'(exp_q.pop_front()));
          accepted++;
          left--;
          if (left == 0) busy = 1'b0;
        end
      end
      if (start && !was_busy) begin
        busy = 1'b1;
        left = NPIX;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(exp_pix(i));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(input string name, input bit random_ready);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20 * NPIX) begin
      pix_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(done), 32'(1));
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: ready held high, latency and throughput.
    pix_ready = 1'b1;
    pulse_start();
    n = 0;
    while (done !== 1'b1 && n < NPIX + 100) begin
      if (n == LAT) check("lat_early", 32'(pix_valid), 32'(0));
      if (n == LAT + 1)
        check("lat_first", 32'({pix_valid, pix_sof, pix_data}), 32'({1'b1, 1'b1, mem[0]}));
      @(posedge clk); #1;
      n++;
    end
    check("frame_cycles", 32'(n), 32'(NPIX + LAT + 1));

    // Frame 2: consumer stalled, FIFO fills to exactly its depth.
    @(posedge clk); #1;
    base = issued;
    pix_ready = 1'b0;
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    check("fill_reads", 32'(issued - base), 32'(DEPTH));
    check("fill_re_idle", 32'(frame_buf_re), 32'(0));
    check("fill_head", 32'({pix_valid, pix_sof, pix_data}), 32'({1'b1, 1'b1, mem[0]}));

    // Then random backpressure with stray start pulses mid-frame.
    n = 0;
    while (done !== 1'b1 && n < 20 * NPIX) begin
      pix_ready = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("frame2_done", 32'(done), 32'(1));

    // Frame 3: start on the eof-accept cycle, then back-to-back start.
    @(posedge clk); #1;
    pix_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!(pix_valid && pix_eof) && n < NPIX + 100) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("eof_start_ignored", 32'(done), 32'(1));
    pulse_start();
    check("b2b_started", 32'(done), 32'(0));
    run_to_done("frame4_done", 1'b1);

    // Frame 5: asynchronous reset part-way through, then a clean restart.
    @(posedge clk); #1;
    base = accepted;
    pix_ready = 1'b1;
    pulse_start();
    n = 0;
    while (accepted - base < 100 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst",
          32'({done, frame_buf_re, frame_buf_addr, pix_valid, pix_sof, pix_eol, pix_eof}),
          32'({1'b1, 1'b0, 17'd0, 4'b0000}));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    run_to_done("restart_done", 1'b1);

    @(posedge clk); #1;
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("reads_match_pixels", 32'(issued), 32'(accepted));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
